// File: rtl/timer_pkg.sv
// timer_pkg: register map, CTRL layout and reset constants of the machine timer
package timer_pkg;
  localparam logic [2:0] TMR_MTIME_LO    = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI    = 3'd1;
  localparam logic [2:0] TMR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] TMR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] TMR_CTRL        = 3'd4;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits one tick every div+1 enabled cycles, restartable by clr
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] cnt;
  assign tick = en && (cnt == div);
  // count enabled cycles, wrap on tick, restart on a CTRL write
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped 64-bit mtime/mtimecmp timer with level interrupt
module timer_unit
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        timer_interrupt
);
  logic [63:0] mtime, mtimecmp;
  logic en;
  logic [PRESCALE_W-1:0] div;
  logic [31:0] ctrl_word;
  logic [2:0] sel;
  logic we, tick, unused_addr;
  assign sel = addr[4:2];
  assign hit = addr[31:5] == BASE_ADDR[31:5];
  assign we = wr_en && hit;
  assign unused_addr = ^addr[1:0];
  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk(clk),
    .rst(rst),
    .en(en),
    .div(div),
    .clr(we && sel == TMR_CTRL),
    .tick(tick)
  );
  // CTRL as seen on the bus; unimplemented bits read zero
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = en;
    ctrl_word[CTRL_DIV_LSB +: PRESCALE_W] = div;
  end
  // combinational read mux, zero unless a load hits the window
  always_comb
    rdata = !(rd_en && hit)           ? 32'h0 :
            sel == TMR_MTIME_LO    ? mtime[31:0] :
            sel == TMR_MTIME_HI    ? mtime[63:32] :
            sel == TMR_MTIMECMP_LO ? mtimecmp[31:0] :
            sel == TMR_MTIMECMP_HI ? mtimecmp[63:32] :
            sel == TMR_CTRL        ? ctrl_word : 32'h0;
  // mtime: a software write to either half beats the tick increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) mtime <= '0;
    else if (we && sel == TMR_MTIME_LO) mtime <= {mtime[63:32], wdata};
    else if (we && sel == TMR_MTIME_HI) mtime <= {wdata, mtime[31:0]};
    else if (tick) mtime <= mtime + 64'd1;
  // mtimecmp halves are written independently
  always_ff @(posedge clk or negedge rst)
    if (!rst) mtimecmp <= MTIMECMP_RST;
    else if (we && sel == TMR_MTIMECMP_LO) mtimecmp <= {mtimecmp[63:32], wdata};
    else if (we && sel == TMR_MTIMECMP_HI) mtimecmp <= {wdata, mtimecmp[31:0]};
  // control register: enable and prescaler divide
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en  <= 1'b0;
      div <= '0;
    end else if (we && sel == TMR_CTRL) begin
      en  <= wdata[CTRL_EN_BIT];
      div <= wdata[CTRL_DIV_LSB +: PRESCALE_W];
    end
  // registered level interrupt from the current compare result
  always_ff @(posedge clk or negedge rst)
    if (!rst) timer_interrupt <= 1'b0;
    else timer_interrupt <= en && (mtime >= mtimecmp);
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: random and directed checks of timer_unit against a behavioural model
module tb_timer_unit;
  localparam logic [31:0] BASE = 32'h0000_2000;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = '0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic hit, timer_interrupt;
  logic [31:0] rdata;
  int checks = 0;
  int errors = 0;
  logic [63:0] m_time = 64'd0;
  logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic m_en = 1'b0;
  int m_div = 0;
  longint m_k = 0;
  logic m_irq = 1'b0;

  timer_unit #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wdata(wdata),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .hit(hit),
    .rdata(rdata),
    .timer_interrupt(timer_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic m_hit();
    return addr[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!(rd_en && m_hit())) return 32'h0;
    case (addr[4:2])
      3'd0: return m_time[31:0];
      3'd1: return m_time[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {16'h0, m_div[7:0], 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: mtime advances once per (div+1) enabled cycles counted from the last CTRL write
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_time = 64'd0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en = 1'b0;
      m_div = 0;
      m_k = 0;
      m_irq = 1'b0;
    end else begin
      logic tick;
      logic [63:0] nt;
      tick = m_en && ((m_k % longint'(m_div + 1)) == longint'(m_div));
      m_irq = m_en && (m_time >= m_cmp);
      nt = tick ? m_time + 64'd1 : m_time;
      if (m_en) m_k++;
      if (wr_en && m_hit()) begin
        case (addr[4:2])
          3'd0: nt = {m_time[63:32], wdata};
          3'd1: nt = {wdata, m_time[31:0]};
          3'd2: m_cmp = {m_cmp[63:32], wdata};
          3'd3: m_cmp = {wdata, m_cmp[31:0]};
          3'd4: begin
            m_en = wdata[0];
            m_div = int'(wdata[15:8]);
            m_k = 0;
          end
          default: ;
        endcase
      end
      m_time = nt;
    end
  end

  // every cycle, away from the edge, compare all outputs with the model
  initial forever begin
    @(negedge clk);
    chk("hit", 64'(hit), 64'(m_hit()));
    chk("rdata", 64'(rdata), 64'(m_rdata()));
    chk("irq", 64'(timer_interrupt), 64'(m_irq));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    addr = BASE + {27'h0, off, 2'b00};
    wdata = d;
    wr_en = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [2:0] off, input logic [31:0] exp);
    addr = BASE + {27'h0, off, 2'b00};
    rd_en = 1'b1;
    wr_en = 1'b0;
    #1;
    chk(name, 64'(rdata), 64'(exp));
  endtask

  initial begin
    logic [31:0] m0;
    logic [2:0] off;
    int r;
    step(3);
    chk("rst_irq", 64'(timer_interrupt), 64'd0);
    expect_rd("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    expect_rd("rst_ctrl", 3'd4, 32'h0);
    rst = 1'b1;
    step(1);
    expect_rd("rst_mtime_lo", 3'd0, 32'h0);
    wr(3'd4, 32'h1);
    for (int i = 0; i < 5; i++) begin
      expect_rd("count_div0", 3'd0, 32'(i));
      chk("no_irq", 64'(timer_interrupt), 64'd0);
      step(1);
    end
    wr(3'd4, 32'h0301);
    addr = BASE;
    rd_en = 1'b1;
    #1 m0 = rdata;
    step(3);
    expect_rd("div3_hold", 3'd0, m0);
    step(1);
    expect_rd("div3_tick", 3'd0, m0 + 1);
    step(2);
    wr(3'd4, 32'h0301);
    step(3);
    expect_rd("div3_restart_hold", 3'd0, m0 + 1);
    step(1);
    expect_rd("div3_restart_tick", 3'd0, m0 + 2);
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h1);
    step(10);
    expect_rd("cmp_mtime10", 3'd0, 32'd10);
    chk("cmp_irq_c10", 64'(timer_interrupt), 64'd0);
    step(1);
    chk("cmp_irq_c11", 64'(timer_interrupt), 64'd1);
    wr(3'd2, 32'd100);
    chk("cmp_raise_edge", 64'(timer_interrupt), 64'd1);
    step(1);
    chk("cmp_raise_drop", 64'(timer_interrupt), 64'd0);
    wr(3'd4, 32'h0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd4, 32'h1);
    expect_rd("wrap_pre", 3'd0, 32'hFFFF_FFFF);
    step(1);
    expect_rd("wrap_lo", 3'd0, 32'h0);
    expect_rd("wrap_hi", 3'd1, 32'h0);
    wr(3'd4, 32'h0);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'd5);
    wr(3'd4, 32'h1);
    step(1);
    expect_rd("carry_hi", 3'd1, 32'd6);
    expect_rd("carry_lo", 3'd0, 32'd0);
    wr(3'd0, 32'h55);
    expect_rd("wr_wins_lo", 3'd0, 32'h55);
    expect_rd("wr_wins_hi", 3'd1, 32'd6);
    step(1);
    expect_rd("after_wr_tick", 3'd0, 32'h56);
    expect_rd("reserved", 3'd6, 32'h0);
    addr = 32'h0000_3000;
    #1;
    chk("outside_hit", 64'(hit), 64'd0);
    chk("outside_rdata", 64'(rdata), 64'd0);
    wr(3'd4, 32'hFFFF_FFFF);
    expect_rd("ctrl_mask", 3'd4, 32'h0000_FF01);
    wr(3'd4, 32'h1);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'h0);
    step(2);
    chk("irq_active", 64'(timer_interrupt), 64'd1);
    addr = BASE + 32'h10;
    rd_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async_irq", 64'(timer_interrupt), 64'd0);
    chk("async_ctrl", 64'(rdata), 64'd0);
    expect_rd("async_cmp", 3'd3, 32'hFFFF_FFFF);
    expect_rd("async_mtime", 3'd0, 32'h0);
    step(2);
    rst = 1'b1;
    step(1);
    wr(3'd4, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      off = 3'($urandom_range(0, 7));
      addr = {($urandom_range(0, 15) == 0) ? 27'h180 : BASE[31:5], off, 2'($urandom_range(0, 3))};
      rd_en = 1'($urandom_range(0, 1));
      wr_en = r < 15;
      case (off)
        3'd0: wdata = $urandom;
        3'd1: wdata = 32'($urandom_range(0, 2));
        3'd2: wdata = m_time[31:0] + 32'($urandom_range(0, 40));
        3'd3: wdata = m_time[63:32] + 32'($urandom_range(0, 1));
        3'd4: wdata = ($urandom & 32'hFFFF_00FE) | {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 3) != 0)};
        default: wdata = $urandom;
      endcase
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
